// File: rtl/pla_core.sv
// rtl/pla_core.sv - registered 3-input / 4-output field-programmable logic array
module pla_core (
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  input  logic       x,
  input  logic       y,
  input  logic       z,
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_we,
  input  logic       cfg_sel,
  input  logic [2:0] cfg_addr,
  input  logic [7:0] cfg_wdata
);

  logic [6:0] and_plane [8];
  logic [7:0] or_plane  [4];
  logic [5:0] literals;
  logic [7:0] products;
  logic [3:0] funcs;

  // Default term i: enabled, one literal of each pair chosen by the bits of i.
  function automatic logic [6:0] minterm_term(input logic [2:0] idx);
    minterm_term = {1'b1,
                    idx[2] ? 2'b10 : 2'b01,
                    idx[1] ? 2'b10 : 2'b01,
                    idx[0] ? 2'b10 : 2'b01};
  endfunction

  assign literals = {x, ~x, y, ~y, z, ~z};

  // Unselected literals are forced high so an enabled empty term is 1.
  always_comb begin
    products = '0;
    for (int i = 0; i < 8; i++) begin
      products[i] = and_plane[i][6] & (&(~and_plane[i][5:0] | literals));
    end
  end

  always_comb begin
    funcs = '0;
    for (int k = 0; k < 4; k++) begin
      funcs[k] = |(or_plane[k] & products);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        and_plane[i] <= minterm_term(3'(i));
      end
      or_plane[0] <= 8'h56;
      or_plane[1] <= 8'hC3;
      or_plane[2] <= 8'h44;
      or_plane[3] <= 8'hAE;
      A <= 1'b0;
      B <= 1'b0;
      C <= 1'b0;
      D <= 1'b0;
    end else begin
      if (cfg_we) begin
        if (cfg_sel) begin
          or_plane[cfg_addr[1:0]] <= cfg_wdata;
        end else begin
          and_plane[cfg_addr] <= cfg_wdata[6:0];
        end
      end
      A <= funcs[0];
      B <= funcs[1];
      C <= funcs[2];
      D <= funcs[3];
    end
  end

endmodule

// File: tb/tb_pla_core.sv
// tb/tb_pla_core.sv - directed vector bench for pla_core
module tb_pla_core;

  logic       A, B, C, D;
  logic       x, y, z;
  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic       cfg_sel;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_wdata;

  int total;
  int bad;

  typedef struct {
    logic [2:0] xyz;
    logic [3:0] abcd;
  } vec_t;

  vec_t sweep [9];

  pla_core dut (
    .A(A), .B(B), .C(C), .D(D),
    .x(x), .y(y), .z(z),
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] want);
    total++;
    if ({A, B, C, D} !== want) begin
      bad++;
      $display("FAIL %s: got ABCD=%b want ABCD=%b", name, {A, B, C, D}, want);
    end
  endtask

  task automatic apply(input logic [2:0] xyz);
    {x, y, z} = xyz;
    step();
  endtask

  task automatic cfg_write(input logic sel, input logic [2:0] addr, input logic [7:0] data);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_addr  = addr;
    cfg_wdata = data;
    step();
    cfg_we    = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    sweep[0] = '{3'b000, 4'b0100};
    sweep[1] = '{3'b001, 4'b1101};
    sweep[2] = '{3'b010, 4'b1011};
    sweep[3] = '{3'b100, 4'b1000};
    sweep[4] = '{3'b011, 4'b0001};
    sweep[5] = '{3'b101, 4'b0001};
    sweep[6] = '{3'b110, 4'b1110};
    sweep[7] = '{3'b111, 4'b0101};
    sweep[8] = '{3'b000, 4'b0100};

    rst = 1'b1;
    {x, y, z} = 3'b001;
    cfg_we = 1'b0;
    cfg_sel = 1'b0;
    cfg_addr = '0;
    cfg_wdata = '0;
    #2;
    check("reset_async", 4'b0000);
    step();
    check("reset_held_edge", 4'b0000);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      apply(sweep[i].xyz);
      check($sformatf("sweep_%0d_xyz%b", i, sweep[i].xyz), sweep[i].abcd);
    end

    // A = m7 only; B, C, D keep defaults
    cfg_write(1'b1, 3'd0, 8'h80);
    apply(3'b111);
    check("or_prog_111", 4'b1101);
    apply(3'b001);
    check("or_prog_001", 4'b0101);

    // T0 = x, C = P0
    cfg_write(1'b0, 3'd0, 8'h60);
    cfg_write(1'b1, 3'd6, 8'h01);
    apply(3'b100);
    check("and_prog_100", 4'b0110);
    apply(3'b011);
    check("and_prog_011", 4'b0001);

    // T0 enabled with no literals: always true
    cfg_write(1'b0, 3'd0, 8'hC0);
    apply(3'b011);
    check("empty_term_011", 4'b0111);
    apply(3'b101);
    check("empty_term_101", 4'b0111);

    // Reset between edges discards all programming
    #2;
    rst = 1'b1;
    #1;
    check("mid_reset_async", 4'b0000);
    rst = 1'b0;
    apply(3'b010);
    check("post_reset_010", 4'b1011);

    cfg_write(1'b0, 3'd2, 8'h00);
    apply(3'b010);
    check("disable_t2_010", 4'b0000);

    // Write on the same edge as evaluation uses old contents
    {x, y, z} = 3'b001;
    cfg_write(1'b1, 3'd3, 8'h00);
    check("collision_edge", 4'b1101);
    step();
    check("collision_next", 4'b1100);

    #2;
    rst = 1'b1;
    #1;
    check("reset_pulse_async", 4'b0000);
    rst = 1'b0;
    apply(3'b001);
    check("reset_pulse_001", 4'b1101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
